// File: rtl/microarchtrace_event_arbiter_if.sv
// Event-in / merged-event-out bundle for the trace arbiter.
// MICROARCHTRACE_DROP_CNT_EN adds the per-source drop counters.
interface microarchtrace_event_arbiter_if #(
    parameter int NSRC   = 3,
    parameter int TS_W   = 32,
    parameter int TYPE_W = 4
);
    localparam int SRC_W = $clog2(NSRC);

    logic                   trace_en;
    logic [NSRC-1:0]        ev_valid;
    logic [NSRC*TYPE_W-1:0] ev_type;
    logic [NSRC*32-1:0]     ev_pc;
    logic [NSRC*32-1:0]     ev_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [SRC_W-1:0]       out_src;
    logic [TYPE_W-1:0]      out_type;
    logic [31:0]            out_pc;
    logic [31:0]            out_data;
    logic [TS_W-1:0]        out_ts;
    logic                   out_lost;
    logic                   overflow;
`ifdef MICROARCHTRACE_DROP_CNT_EN
    logic [NSRC*16-1:0]     drop_cnt;
`endif

    // master: monitors plus trace sink; slave: the arbiter
    modport master (
        output trace_en, ev_valid, ev_type, ev_pc, ev_data, out_ready,
`ifdef MICROARCHTRACE_DROP_CNT_EN
        input  drop_cnt,
`endif
        input  out_valid, out_src, out_type, out_pc, out_data, out_ts, out_lost, overflow
    );

    modport slave (
        input  trace_en, ev_valid, ev_type, ev_pc, ev_data, out_ready,
`ifdef MICROARCHTRACE_DROP_CNT_EN
        output drop_cnt,
`endif
        output out_valid, out_src, out_type, out_pc, out_data, out_ts, out_lost, overflow
    );
endinterface

// File: rtl/microarchtrace_event_arbiter.sv
// Merges per-source trace events into one oldest-first stream via per-source FIFOs.
// MICROARCHTRACE_DROP_CNT_EN adds 16-bit saturating per-source drop counters.
module microarchtrace_event_arbiter #(
    parameter int NSRC   = 3,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 32,
    parameter int TYPE_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    microarchtrace_event_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(NSRC);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [TYPE_W-1:0] typ;
        logic [31:0]       pc;
        logic [31:0]       data;
        logic [TS_W-1:0]   ts;
        logic              lost;
    } entry_t;

    entry_t          mem [NSRC][DEPTH];
    logic [PTR_W:0]  wr_ptr [NSRC];
    logic [PTR_W:0]  rd_ptr [NSRC];
    entry_t          head [NSRC];
    logic [NSRC-1:0] empty, full, push_req, push_ok, drop, pop, lost_q;
    logic [TS_W-1:0] ts_q, sel_ts, diff;
    entry_t          sel_entry, out_q;
    logic [SRC_W-1:0] sel, out_src_q;
    logic            sel_any, load, out_valid_q, overflow_q;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][PTR_W-1:0] == rd_ptr[i][PTR_W-1:0]) &&
                       (wr_ptr[i][PTR_W] != rd_ptr[i][PTR_W]);
            head[i]  = mem[i][rd_ptr[i][PTR_W-1:0]];
        end
    end

    // Strictly-older test keeps the lowest index on equal timestamps.
    always_comb begin
        sel       = '0;
        sel_any   = 1'b0;
        sel_ts    = '0;
        sel_entry = '0;
        diff      = '0;
        for (int i = 0; i < NSRC; i++) begin
            diff = head[i].ts - sel_ts;
            if (!empty[i] && (!sel_any || diff[TS_W-1])) begin
                sel       = SRC_W'(i);
                sel_any   = 1'b1;
                sel_ts    = head[i].ts;
                sel_entry = head[i];
            end
        end
    end

    assign load     = sel_any && (!out_valid_q || bus.out_ready);
    assign push_req = bus.ev_valid & {NSRC{bus.trace_en}};

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            pop[i]     = load && (sel == SRC_W'(i));
            push_ok[i] = push_req[i] && (!full[i] || pop[i]);
            drop[i]    = push_req[i] && full[i] && !pop[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (push_ok[i]) begin
                mem[i][wr_ptr[i][PTR_W-1:0]] <= {bus.ev_type[i*TYPE_W +: TYPE_W],
                                                 bus.ev_pc[i*32 +: 32],
                                                 bus.ev_data[i*32 +: 32],
                                                 ts_q, lost_q[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q        <= '0;
            lost_q      <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_src_q   <= '0;
            for (int i = 0; i < NSRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            ts_q <= ts_q + 1'b1;
            if (|drop) overflow_q <= 1'b1;
            for (int i = 0; i < NSRC; i++) begin
                if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])     rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push_ok[i])   lost_q[i] <= 1'b0;
                else if (drop[i]) lost_q[i] <= 1'b1;
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_q       <= sel_entry;
                out_src_q   <= sel;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_type  = out_q.typ;
    assign bus.out_pc    = out_q.pc;
    assign bus.out_data  = out_q.data;
    assign bus.out_ts    = out_q.ts;
    assign bus.out_lost  = out_q.lost;
    assign bus.overflow  = overflow_q;

`ifdef MICROARCHTRACE_DROP_CNT_EN
    logic [15:0] drop_cnt_q [NSRC];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (!rst_n)
                drop_cnt_q[i] <= '0;
            else if (drop[i] && (drop_cnt_q[i] != 16'hFFFF))
                drop_cnt_q[i] <= drop_cnt_q[i] + 1'b1;
        end
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_drop_cnt
        assign bus.drop_cnt[g*16 +: 16] = drop_cnt_q[g];
    end
`endif
endmodule

// File: tb/tb_microarchtrace_event_arbiter.sv
// Self-checking bench: expected events queued at drive time, compared as the sink accepts them.
// A second instance with TS_W=4 covers timestamp wrap ordering.
module tb_microarchtrace_event_arbiter;
    localparam int NSRC = 3, DEPTH = 4, TS_W = 32, TYPE_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    microarchtrace_event_arbiter_if #(.NSRC(NSRC), .TS_W(TS_W), .TYPE_W(TYPE_W)) bus ();
    microarchtrace_event_arbiter_if #(.NSRC(NSRC), .TS_W(4), .TYPE_W(TYPE_W)) wbus ();

    microarchtrace_event_arbiter #(.NSRC(NSRC), .DEPTH(DEPTH), .TS_W(TS_W), .TYPE_W(TYPE_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    microarchtrace_event_arbiter #(.NSRC(NSRC), .DEPTH(DEPTH), .TS_W(4), .TYPE_W(TYPE_W)) wdut (
        .clk(clk), .rst_n(rst_n), .bus(wbus));

    typedef struct {
        logic [1:0]  src;
        logic [3:0]  typ;
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] ts;
        logic        lost;
    } exp_t;

    typedef struct {
        logic [2:0] valid;
        logic       en;
        logic       rdy;
        logic       exp_v;
    } vec_t;

    exp_t sb[$];
    exp_t wq[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] tb_ts;

    // Reference timestamp: free-running cycle count since reset.
    always @(posedge clk) begin
        if (!rst_n) tb_ts <= '0;
        else        tb_ts <= tb_ts + 1;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got src=%0d pc=%h ts=%0d", bus.out_src, bus.out_pc, bus.out_ts);
            end else begin
                e = sb.pop_front();
                if (bus.out_src !== e.src || bus.out_type !== e.typ || bus.out_pc !== e.pc ||
                    bus.out_data !== e.data || bus.out_ts !== e.ts || bus.out_lost !== e.lost) begin
                    errors++;
                    $display("FAIL out_event got src=%0d type=%0d pc=%h data=%h ts=%0d lost=%b exp src=%0d type=%0d pc=%h data=%h ts=%0d lost=%b",
                             bus.out_src, bus.out_type, bus.out_pc, bus.out_data, bus.out_ts, bus.out_lost,
                             e.src, e.typ, e.pc, e.data, e.ts, e.lost);
                end
            end
        end
        if (rst_n && wbus.out_valid && wbus.out_ready) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL wrap_unexpected got src=%0d ts=%0d", wbus.out_src, wbus.out_ts);
            end else begin
                e = wq.pop_front();
                if (wbus.out_src !== e.src || wbus.out_pc !== e.pc || {28'b0, wbus.out_ts} !== e.ts) begin
                    errors++;
                    $display("FAIL wrap_event got src=%0d pc=%h ts=%0d exp src=%0d pc=%h ts=%0d",
                             wbus.out_src, wbus.out_pc, wbus.out_ts, e.src, e.pc, e.ts);
                end
            end
        end
        @(posedge clk);
        #1;
        bus.ev_valid  = '0;
        wbus.ev_valid = '0;
    endtask

    task automatic ev(input int s, input logic [3:0] typ, input logic [31:0] pc,
                      input logic lost, input logic dropped);
        exp_t e;
        bus.ev_valid[s]                 = 1'b1;
        bus.ev_type[s*TYPE_W +: TYPE_W] = typ;
        bus.ev_pc[s*32 +: 32]           = pc;
        bus.ev_data[s*32 +: 32]         = ~pc;
        if (bus.trace_en && !dropped) begin
            e.src = 2'(s); e.typ = typ; e.pc = pc; e.data = ~pc; e.ts = tb_ts; e.lost = lost;
            sb.push_back(e);
        end
    endtask

    task automatic wev(input int s, input logic [31:0] pc);
        exp_t e;
        wbus.ev_valid[s]                 = 1'b1;
        wbus.ev_type[s*TYPE_W +: TYPE_W] = 4'h0;
        wbus.ev_pc[s*32 +: 32]           = pc;
        wbus.ev_data[s*32 +: 32]         = '0;
        e.src = 2'(s); e.typ = 4'h0; e.pc = pc; e.data = '0; e.ts = {28'b0, tb_ts[3:0]}; e.lost = 1'b0;
        wq.push_back(e);
    endtask

    task automatic drain(input int max_cyc);
        for (int n = 0; n < max_cyc && (sb.size() != 0 || wq.size() != 0); n++) step();
        chk("drain_left", 32'(sb.size() + wq.size()), 32'd0);
    endtask

    task automatic do_reset(input logic flush);
        if (!flush) chk("sb_empty_before_reset", 32'(sb.size() + wq.size()), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb.delete();
        wq.delete();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_ts", bus.out_ts, 32'd0);
        chk("rst_wrap_valid", 32'(wbus.out_valid), 32'd0);
    endtask

    vec_t vt[11];

    initial begin
        vt[0]  = '{3'b001, 1'b1, 1'b1, 1'b0};
        vt[1]  = '{3'b000, 1'b1, 1'b1, 1'b1};
        vt[2]  = '{3'b111, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{3'b000, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{3'b010, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{3'b000, 1'b1, 1'b1, 1'b1};
        vt[6]  = '{3'b100, 1'b0, 1'b1, 1'b1};
        vt[7]  = '{3'b101, 1'b1, 1'b1, 1'b1};
        vt[8]  = '{3'b000, 1'b1, 1'b1, 1'b1};
        vt[9]  = '{3'b000, 1'b1, 1'b1, 1'b1};
        vt[10] = '{3'b000, 1'b1, 1'b1, 1'b0};

        bus.trace_en = 1'b0;  bus.ev_valid = '0;  bus.ev_type = '0;
        bus.ev_pc = '0;       bus.ev_data = '0;   bus.out_ready = 1'b0;
        wbus.trace_en = 1'b0; wbus.ev_valid = '0; wbus.ev_type = '0;
        wbus.ev_pc = '0;      wbus.ev_data = '0;  wbus.out_ready = 1'b0;

        // Single source at ts=5
        do_reset(1'b1);
        bus.trace_en = 1'b1; bus.out_ready = 1'b1;
        for (int n = 0; n < 5; n++) step();
        ev(0, 4'h1, 32'h80, 1'b0, 1'b0);
        step();
        chk("single_not_yet", 32'(bus.out_valid), 32'd0);
        step();
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_src", 32'(bus.out_src), 32'd0);
        chk("single_pc", bus.out_pc, 32'h80);
        chk("single_ts", bus.out_ts, 32'd5);
        chk("single_lost", 32'(bus.out_lost), 32'd0);
        step();
        chk("single_done", 32'(bus.out_valid), 32'd0);

        // Table-driven vectors
        do_reset(1'b0);
        for (int r = 0; r < 11; r++) begin
            bus.trace_en  = vt[r].en;
            bus.out_ready = vt[r].rdy;
            for (int s = 0; s < NSRC; s++)
                if (vt[r].valid[s]) ev(s, 4'(r), 32'h100 + 32'(r * 16 + s), 1'b0, 1'b0);
            step();
            chk($sformatf("vec%0d_valid", r), 32'(bus.out_valid), 32'(vt[r].exp_v));
        end
        bus.trace_en = 1'b1;
        drain(10);

        // Simultaneous: src1@9 buffered, then src0/src2@10
        do_reset(1'b0);
        bus.out_ready = 1'b0;
        for (int n = 0; n < 9; n++) step();
        ev(1, 4'h2, 32'h900, 1'b0, 1'b0);
        step();
        ev(0, 4'h3, 32'hA00, 1'b0, 1'b0);
        ev(2, 4'h4, 32'hA02, 1'b0, 1'b0);
        step();
        bus.out_ready = 1'b1;
        drain(10);

        // Full FIFO with pop in the same cycle
        do_reset(1'b0);
        bus.out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            ev(0, 4'h5, 32'h2000 + 32'(n), 1'b0, 1'b0);
            step();
        end
        bus.out_ready = 1'b1;
        ev(0, 4'h5, 32'h2005, 1'b0, 1'b0);
        step();
        chk("fullpop_overflow", 32'(bus.overflow), 32'd0);
        drain(12);
        chk("fullpop_overflow_end", 32'(bus.overflow), 32'd0);

        // Back-pressure overflow on src1
        do_reset(1'b0);
        bus.out_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (n == 5) chk("ovf_before_drop", 32'(bus.overflow), 32'd0);
            ev(1, 4'h6, 32'h3000 + 32'(n), 1'b0, n == 5);
            step();
        end
        chk("ovf_set", 32'(bus.overflow), 32'd1);
`ifdef MICROARCHTRACE_DROP_CNT_EN
        chk("drop_cnt1", 32'(bus.drop_cnt[31:16]), 32'd1);
        chk("drop_cnt0", 32'(bus.drop_cnt[15:0]), 32'd0);
`endif
        bus.out_ready = 1'b1;
        drain(12);
        ev(1, 4'h7, 32'h3100, 1'b1, 1'b0);
        step();
        ev(1, 4'h7, 32'h3101, 1'b0, 1'b0);
        step();
        drain(8);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Reset mid-stream
        bus.out_ready = 1'b0;
        ev(0, 4'h8, 32'h4000, 1'b0, 1'b0);
        ev(1, 4'h8, 32'h4001, 1'b0, 1'b0);
        ev(2, 4'h8, 32'h4002, 1'b0, 1'b0);
        step();
        step();
        ev(0, 4'h8, 32'h4003, 1'b0, 1'b0);
        step();
        chk("mid_valid_before", 32'(bus.out_valid), 32'd1);
        do_reset(1'b1);
        bus.out_ready = 1'b1;
        ev(2, 4'h9, 32'h5000, 1'b0, 1'b0);
        step();
        step();
        chk("mid_new_ts", bus.out_ts, 32'd0);
        chk("mid_new_pc", bus.out_pc, 32'h5000);
        for (int n = 0; n < 8; n++) step();
        chk("mid_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("sb_after_mid", 32'(sb.size()), 32'd0);

        // Timestamp wrap on the TS_W=4 instance
        do_reset(1'b0);
        bus.trace_en   = 1'b0;
        wbus.trace_en  = 1'b1;
        wbus.out_ready = 1'b0;
        for (int n = 0; n < 14; n++) step();
        wev(2, 32'h60E);
        step();
        wev(0, 32'h60F);
        step();
        wev(1, 32'h600);
        step();
        wbus.out_ready = 1'b1;
        drain(10);
        chk("wrap_idle_valid", 32'(wbus.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/microarchtrace_event_arbiter.md
Name: microarchtrace_event_arbiter

Overview:
Merges per-stage microarchitectural trace events (fetch, ID/EX, multicycle end, etc.) from NSRC independent monitors into one time-ordered event stream.
- Each event is timestamped at capture and buffered per source.
- The oldest event is forwarded over a valid/ready port to the trace sink (DPI bridge or trace-port serializer).
- Sources are non-stallable because the core must never be back-pressured. Overflow drops events and marks the loss.

Parameters:
NSRC, 3, number of event sources (2..8)
DEPTH, 4, per-source FIFO depth in entries (power of two, >=2)
TS_W, 32, timestamp width in bits
TYPE_W, 4, event type code width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
trace_en  in  1  capture enable; 0 = ignore all ev_valid
ev_valid  in  NSRC  per-source event strobe, one event per cycle per source
ev_type  in  NSRC*TYPE_W  per-source event type, source i at [i*TYPE_W +: TYPE_W]
ev_pc  in  NSRC*32  per-source PC
ev_data  in  NSRC*32  per-source payload (insn word, compressed insn, etc.)
out_valid  out  1  output event valid
out_ready  in  1  sink accepts event
out_src  out  $clog2(NSRC)  source index of output event
out_type  out  TYPE_W  event type
out_pc  out  32  event PC
out_data  out  32  event payload
out_ts  out  TS_W  capture timestamp
out_lost  out  1  at least one event from out_src was dropped before this one
overflow  out  1  sticky; set on any drop, cleared only by reset

Behaviour:
- Reset (rst_n=0 at posedge): all FIFOs flushed; timestamp counter = 0; all per-source lost flags = 0; out_valid = 0; all out_* data = 0; overflow = 0. Reset mid-operation discards all buffered and presented events.
- Timestamp counter: increments by 1 every cycle out of reset, regardless of trace_en. Wraps modulo 2^TS_W.
- Capture:
  - At a posedge with trace_en=1 and ev_valid[i]=1, {type, pc, data, ts, lost_i} is pushed into FIFO i. ts is the counter value before the edge.
  - The push is accepted if FIFO i is not full, or if FIFO i is popped in the same cycle.
  - On an accepted push, lost_i is cleared.
- Overflow:
  - If FIFO i is full and not popped, the event is dropped, lost_i is set and overflow is set.
  - The next accepted event from source i carries lost=1.
- Selection:
  - Among non-empty FIFOs, the head with the oldest ts is chosen.
  - Age comparison is wrap-safe: a is older than b iff the signed TS_W-bit value (a-b) < 0.
  - Equal ts: the lowest source index wins.
- Output register:
  - One-entry registered stage.
  - It loads the selected head (and pops that FIFO) when out_valid=0 or out_ready=1.
  - out_valid asserts after the load edge.
  - out_* are held stable while out_valid=1 and out_ready=0.
- Latency: an event captured at edge N appears on out_* after edge N+1 if the output stage is free and it is oldest. Sustained throughput is 1 event/cycle with out_ready=1.
- Ordering: events from the same source leave in capture order. Cross-source order is by ts, among events present in the FIFOs at selection time.
- trace_en deassert: capture stops immediately. Buffered events still drain. Lost flags are kept.
- Empty: out_valid drops after the edge that accepts the last event, when all FIFOs are empty.

Optional Feature:
MICROARCHTRACE_DROP_CNT_EN
- Defined: adds output drop_cnt [NSRC*16] with one 16-bit saturating counter per source.
  - Each counter increments on each dropped event and holds at 0xFFFF.
  - Counters reset to 0.
- Undefined: no drop_cnt port and no counters. overflow/out_lost behaviour is unchanged.

Test Plan:
- Single source: ev_valid[0]=1 at ts=5, type=1, pc=0x80, out_ready=1 -> after next edge out_valid=1, out_src=0, out_pc=0x80, out_ts=5, out_lost=0; then out_valid=0.
- Simultaneous events: src0 and src2 both at ts=10, src1 at ts=9 already buffered -> output order src1(ts9), src0(ts10), src2(ts10).
- Back-pressure and overflow:
  - Stimulus: out_ready=0, src1 pushes 6 events on consecutive cycles (DEPTH=4).
  - Required: 1 in the output register, 4 in the FIFO, 6th dropped; overflow=1.
  - With MICROARCHTRACE_DROP_CNT_EN, drop_cnt[1]=1.
  - After draining, the next src1 event has out_lost=1; the one after has out_lost=0.
- Full-FIFO push with pop: FIFO0 full, out_ready=1, new src0 event in the same cycle -> accepted, no drop, overflow stays 0.
- Timestamp wrap (TS_W=4): src0 event at ts=15, src1 event at ts=0 (after wrap) -> src0 emitted first.
- Reset mid-stream: 3 events buffered, out_valid=1, rst_n=0 for one edge -> out_valid=0, overflow=0; ts restarts at 0; no stale events emitted afterwards.
